toggle_activity_counter: RTL and testbench

Switching-activity accumulator for the power-estimation flow. It samples a bundle of monitored nets, such as a flip-flop's q/qb pair, once per clock over a programmed window. It counts transitions per cycle and accumulates a capacitance-weighted energy figure. The result is presented on a valid/ready handshake to the downstream power-reporting stage, replacing offline VCD toggle counting for on-chip estimation.

---
 rtl/toggle_activity_counter_if.sv | 48 ++++
 rtl/toggle_activity_counter.sv | 138 +++++++++++++
 tb/tb_toggle_activity_counter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/toggle_activity_counter_if.sv
// Bundle of the measurement-control, monitored-net and result-handshake
// signals of toggle_activity_counter. The master side is whoever requests
// measurements and consumes results; the slave side is the counter itself.
interface toggle_activity_counter_if #(
   parameter int NSIG  = 4,
   parameter int CNT_W = 16,
   parameter int WGT_W = 8,
   parameter int ACC_W = 32
);

   logic                    start;
   logic [CNT_W-1:0]        window_len;
   logic [NSIG-1:0]         sig_in;
   logic [NSIG*WGT_W-1:0]   weights;
   logic                    busy;
   logic                    res_valid;
   logic                    res_ready;
   logic [CNT_W-1:0]        toggle_total;
   logic [ACC_W-1:0]        energy;
   logic                    overflow;

   modport master (
      output start,
      output window_len,
      output sig_in,
      output weights,
      output res_ready,
      input  busy,
      input  res_valid,
      input  toggle_total,
      input  energy,
      input  overflow
   );

   modport slave (
      input  start,
      input  window_len,
      input  sig_in,
      input  weights,
      input  res_ready,
      output busy,
      output res_valid,
      output toggle_total,
      output energy,
      output overflow
   );

endinterface

// File: rtl/toggle_activity_counter.sv
// Switching-activity accumulator. Once started it compares the monitored
// nets against their previous sample on every clock of a programmed window,
// summing the number of toggles and a per-net weighted energy figure. Both
// sums saturate at all-ones and raise a sticky overflow flag. The result is
// offered on a valid/ready handshake and stays readable until the next start.
module toggle_activity_counter #(
   parameter int NSIG  = 4,
   parameter int CNT_W = 16,
   parameter int WGT_W = 8,
   parameter int ACC_W = 32
) (
   input logic                     clk,
   input logic                     rst_n,
   toggle_activity_counter_if.slave bus
);

   // Width needed to hold the number of nets toggling in one cycle, and the
   // width of the largest possible single-cycle weighted energy.
   localparam int PW  = $clog2(NSIG + 1);
   localparam int ESW = WGT_W + PW;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COUNT  = 2'd1,
      REPORT = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [NSIG-1:0]   prev_q, prev_d;
   logic [CNT_W-1:0]  tot_q, tot_d;
   logic [ACC_W-1:0]  energy_q, energy_d;
   logic              ovf_q, ovf_d;

   logic [NSIG-1:0]   toggleVec;
   logic [PW-1:0]     togglePop;
   logic [ESW-1:0]    cycleEnergy;
   logic [CNT_W:0]    totSum;
   logic [ACC_W:0]    energySum;
   logic [CNT_W-1:0]  loadLen;

   // Which nets changed since the previous sample, how many, and their summed weight
   always_comb begin
      toggleVec   = bus.sig_in ^ prev_q;
      togglePop   = '0;
      cycleEnergy = '0;
      for (int i = 0; i < NSIG; i++) begin
         if (toggleVec[i]) begin
            togglePop   = togglePop + PW'(1);
            cycleEnergy = cycleEnergy + ESW'(bus.weights[i*WGT_W +: WGT_W]);
         end
      end
   end

   // One-bit-wider sums so a carry out marks the point where saturation is needed
   always_comb begin
      totSum    = {1'b0, tot_q} + (CNT_W + 1)'(togglePop);
      energySum = {1'b0, energy_q} + (ACC_W + 1)'(cycleEnergy);
   end

   // A zero window length is treated as a single compare cycle
   always_comb begin
      loadLen = (bus.window_len == '0) ? CNT_W'(1) : bus.window_len;
   end

   // Next-state logic: window setup in IDLE, accumulation in COUNT, handshake in REPORT
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      prev_d   = prev_q;
      tot_d    = tot_q;
      energy_d = energy_q;
      ovf_d    = ovf_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               cnt_d    = loadLen;
               prev_d   = bus.sig_in;
               tot_d    = '0;
               energy_d = '0;
               ovf_d    = 1'b0;
               state_d  = COUNT;
            end
         end

         COUNT: begin
            prev_d   = bus.sig_in;
            tot_d    = totSum[CNT_W] ? '1 : totSum[CNT_W-1:0];
            energy_d = energySum[ACC_W] ? '1 : energySum[ACC_W-1:0];
            ovf_d    = ovf_q | totSum[CNT_W] | energySum[ACC_W];
            cnt_d    = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = REPORT;
            end
         end

         REPORT: begin
            if (bus.res_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any window in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         prev_q   <= '0;
         tot_q    <= '0;
         energy_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         prev_q   <= prev_d;
         tot_q    <= tot_d;
         energy_q <= energy_d;
         ovf_q    <= ovf_d;
      end
   end

   // Status and result outputs come straight from registered state
   always_comb begin
      bus.busy         = (state_q == COUNT) || (state_q == REPORT);
      bus.res_valid    = (state_q == REPORT);
      bus.toggle_total = tot_q;
      bus.energy       = energy_q;
      bus.overflow     = ovf_q;
   end

endmodule

// File: tb/tb_toggle_activity_counter.sv
// Self-checking bench for toggle_activity_counter. Each window's expected
// result is computed from the whole stimulus sequence with plain arithmetic;
// a compare process checks status and results every cycle, and literal
// values from hand calculation pin the model for the directed scenarios.
module tb_toggle_activity_counter;

   logic clk;
   logic rst_n;

   toggle_activity_counter_if #(.NSIG(4), .CNT_W(16), .WGT_W(8), .ACC_W(32)) bus ();

   toggle_activity_counter #(.NSIG(4), .CNT_W(16), .WGT_W(8), .ACC_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int     errors = 0;
   int     checks = 0;

   bit     checkEn      = 0;
   bit     resultsCheck = 0;
   bit     expBusy      = 0;
   bit     expValid     = 0;
   longint expTot       = 0;
   longint expEn        = 0;
   bit     expOvf       = 0;

   longint modelTot;
   longint modelEn;
   bit     modelOvf;

   localparam logic [31:0] W4321 = {8'd4, 8'd3, 8'd2, 8'd1};

   // 100 MHz-style free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Every cycle, compare status and (when defined) results against the model
   always begin
      @(posedge clk);
      #2;
      if (checkEn) begin
         checkOutput("busy", longint'(bus.busy), longint'(expBusy));
         checkOutput("res_valid", longint'(bus.res_valid), longint'(expValid));
         if (resultsCheck) begin
            checkOutput("toggle_total", longint'(bus.toggle_total), expTot);
            checkOutput("energy", longint'(bus.energy), expEn);
            checkOutput("overflow", longint'(bus.overflow), longint'(expOvf));
         end
      end
   end

   // Run one complete window: start, compare cycles, report hold, handshake, one idle cycle.
   // mode 0 random nets, 1 net0 toggles, 2 all nets toggle, 3 static 4'b1011.
   task automatic applyStimulus(input int len, input int mode, input logic [31:0] wts,
                                input int holdCycles);
      int         w;
      logic [3:0] seq[];
      logic [3:0] x;
      longint     t;
      longint     e;
      bit         o;

      w   = (len == 0) ? 1 : len;
      seq = new[w + 1];
      for (int k = 0; k <= w; k++) begin
         case (mode)
            1:       seq[k] = (k % 2 == 1) ? 4'b0001 : 4'b0000;
            2:       seq[k] = (k % 2 == 1) ? 4'b1111 : 4'b0000;
            3:       seq[k] = 4'b1011;
            default: seq[k] = 4'($urandom);
         endcase
      end

      t = 0;
      e = 0;
      o = 0;
      for (int k = 1; k <= w; k++) begin
         x = seq[k] ^ seq[k-1];
         t += $countones(x);
         for (int i = 0; i < 4; i++) begin
            if (x[i]) e += longint'(wts[i*8 +: 8]);
         end
      end
      if (t > 65535) begin
         t = 65535;
         o = 1;
      end
      if (e > 64'hFFFF_FFFF) begin
         e = 64'hFFFF_FFFF;
         o = 1;
      end
      modelTot = t;
      modelEn  = e;
      modelOvf = o;

      @(negedge clk);
      bus.start      = 1'b1;
      bus.window_len = 16'(len);
      bus.weights    = wts;
      bus.sig_in     = seq[0];
      bus.res_ready  = 1'b0;
      @(posedge clk);
      expBusy      = 1;
      expValid     = 0;
      expTot       = 0;
      expEn        = 0;
      expOvf       = 0;
      resultsCheck = 1;

      for (int k = 1; k <= w; k++) begin
         @(negedge clk);
         bus.start      = 1'($urandom);
         bus.window_len = 16'($urandom);
         bus.sig_in     = seq[k];
         bus.res_ready  = 1'($urandom);
         @(posedge clk);
         if (k == w) begin
            expValid     = 1;
            expTot       = t;
            expEn        = e;
            expOvf       = o;
            resultsCheck = 1;
         end else begin
            resultsCheck = 0;
         end
      end

      for (int h = 0; h < holdCycles; h++) begin
         @(negedge clk);
         bus.res_ready = 1'b0;
         bus.start     = (h % 2 == 0);
         bus.sig_in    = 4'($urandom);
         @(posedge clk);
      end

      @(negedge clk);
      bus.res_ready = 1'b1;
      bus.start     = 1'b1;
      bus.sig_in    = 4'($urandom);
      @(posedge clk);
      expBusy  = 0;
      expValid = 0;

      @(negedge clk);
      bus.res_ready = 1'b0;
      bus.start     = 1'b0;
      @(posedge clk);
      #2;
   endtask

   // Asynchronous reset in the middle of a window
   task automatic resetMidCount();
      checkEn = 0;
      @(negedge clk);
      bus.start      = 1'b1;
      bus.window_len = 16'd8;
      bus.weights    = W4321;
      bus.sig_in     = 4'b0000;
      @(posedge clk);
      @(negedge clk);
      bus.start  = 1'b0;
      bus.sig_in = 4'b0001;
      @(posedge clk);
      @(negedge clk);
      bus.sig_in = 4'b0000;
      @(posedge clk);
      #2;
      checkOutput("pre-reset busy", longint'(bus.busy), 1);
      checkOutput("pre-reset partial toggle_total", longint'(bus.toggle_total), 2);
      checkOutput("pre-reset partial energy", longint'(bus.energy), 2);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("async reset busy", longint'(bus.busy), 0);
      checkOutput("async reset res_valid", longint'(bus.res_valid), 0);
      checkOutput("async reset toggle_total", longint'(bus.toggle_total), 0);
      checkOutput("async reset energy", longint'(bus.energy), 0);
      checkOutput("async reset overflow", longint'(bus.overflow), 0);
      @(negedge clk);
      rst_n        = 1'b1;
      expBusy      = 0;
      expValid     = 0;
      expTot       = 0;
      expEn        = 0;
      expOvf       = 0;
      resultsCheck = 1;
      checkEn      = 1;
   endtask

   initial begin
      rst_n          = 1'b1;
      bus.start      = 1'b0;
      bus.window_len = '0;
      bus.sig_in     = '0;
      bus.weights    = W4321;
      bus.res_ready  = 1'b0;
      #1;
      rst_n = 1'b0;
      #11;
      checkOutput("reset busy", longint'(bus.busy), 0);
      checkOutput("reset res_valid", longint'(bus.res_valid), 0);
      checkOutput("reset toggle_total", longint'(bus.toggle_total), 0);
      checkOutput("reset energy", longint'(bus.energy), 0);
      checkOutput("reset overflow", longint'(bus.overflow), 0);
      @(negedge clk);
      rst_n        = 1'b1;
      resultsCheck = 1;
      checkEn      = 1;

      // net0 toggles every cycle over 8 compares
      applyStimulus(8, 1, W4321, 0);
      checkOutput("s1 model toggles", modelTot, 8);
      checkOutput("s1 model energy", modelEn, 8);
      checkOutput("s1 toggle_total held in idle", longint'(bus.toggle_total), 8);
      checkOutput("s1 energy held in idle", longint'(bus.energy), 8);

      // all nets toggle every cycle over 10 compares
      applyStimulus(10, 2, W4321, 0);
      checkOutput("s2 model toggles", modelTot, 40);
      checkOutput("s2 model energy", modelEn, 100);
      checkOutput("s2 toggle_total held in idle", longint'(bus.toggle_total), 40);

      // static nets, value already present before the window
      @(negedge clk);
      bus.sig_in = 4'b1011;
      @(posedge clk);
      applyStimulus(5, 3, W4321, 0);
      checkOutput("s3 model toggles", modelTot, 0);
      checkOutput("s3 energy held in idle", longint'(bus.energy), 0);

      // zero length behaves as a one-compare window
      applyStimulus(0, 1, W4321, 0);
      checkOutput("len0 model toggles", modelTot, 1);
      checkOutput("len0 toggle_total held in idle", longint'(bus.toggle_total), 1);

      // results held through a stalled report with start pulses
      applyStimulus(6, 0, 32'($urandom), 5);

      // randomized windows
      for (int n = 0; n < 10; n++) begin
         applyStimulus($urandom_range(0, 12), 0, 32'($urandom), $urandom_range(0, 3));
      end

      // toggle total saturates, energy does not
      applyStimulus(20000, 2, W4321, 1);
      checkOutput("sat model toggles", modelTot, 65535);
      checkOutput("sat model energy", modelEn, 200000);
      checkOutput("sat model overflow", longint'(modelOvf), 1);
      checkOutput("sat overflow held in idle", longint'(bus.overflow), 1);
      checkOutput("sat energy held in idle", longint'(bus.energy), 200000);

      resetMidCount();

      // fresh window after reset behaves like the first one
      applyStimulus(8, 1, W4321, 0);
      checkOutput("post-reset toggle_total", longint'(bus.toggle_total), 8);
      checkOutput("post-reset energy", longint'(bus.energy), 8);
      checkOutput("post-reset overflow", longint'(bus.overflow), 0);

      checkEn = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
